// File: rtl/fifo_dma_pkg.sv
// Shared constants and sizing helpers for the DMA datapath FIFO.
package fifo_dma_pkg;

    localparam int unsigned DMA_FIFO_WIDTH = 64;
    localparam int unsigned DMA_FIFO_DEPTH = 5;

    // Occupancy needs one bit more than the index so that "full" is representable.
    function automatic int unsigned fifo_level_w(input int unsigned entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/fifo_dma_ram.sv
// Storage array for the DMA FIFO: one synchronous write port, one asynchronous read port, no reset.
module fifo_dma_ram
    import fifo_dma_pkg::*;
#(
    parameter int unsigned C_WIDTH = DMA_FIFO_WIDTH,
    parameter int unsigned C_DEPTH = DMA_FIFO_DEPTH
) (
    input  logic               clk_i,
    input  logic               we,
    input  logic [C_DEPTH-1:0] waddr,
    input  logic [C_WIDTH-1:0] wdata,
    input  logic [C_DEPTH-1:0] raddr,
    output logic [C_WIDTH-1:0] rdata
);

    logic [C_WIDTH-1:0] mem [2**C_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_dma_flow.sv
// First-word-fall-through synchronous FIFO with level, almost flags, sticky errors, flush and high-water mark.
module fifo_dma_flow
    import fifo_dma_pkg::*;
#(
    parameter int unsigned C_WIDTH  = DMA_FIFO_WIDTH,
    parameter int unsigned C_DEPTH  = DMA_FIFO_DEPTH,
    parameter int unsigned C_AFULL  = 28,
    parameter int unsigned C_AEMPTY = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [C_WIDTH-1:0]   data_i,
    input  logic                 push_i,
    output logic [C_WIDTH-1:0]   data_o,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_empty_o,
    output logic                 almost_full_o,
    output logic [C_DEPTH:0]     level_o,
    output logic [C_DEPTH:0]     hwm_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int unsigned LW = fifo_level_w(2**C_DEPTH);
    localparam logic [LW-1:0] ONE      = LW'(1);
    localparam logic [LW-1:0] AFULL_L  = LW'(C_AFULL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(C_AEMPTY);

    if (C_AFULL < 1 || C_AFULL > 2**C_DEPTH) begin : g_bad_afull
        $error("fifo_dma_flow: C_AFULL must be in 1..2**C_DEPTH");
    end
    if (C_AEMPTY >= 2**C_DEPTH) begin : g_bad_aempty
        $error("fifo_dma_flow: C_AEMPTY must be below 2**C_DEPTH");
    end

    logic [LW-1:0] wr_ptr, rd_ptr, hwm, level, level_nxt;
    logic          empty, full, push_acc, pop_acc, ovf, unf;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[C_DEPTH-1:0] == rd_ptr[C_DEPTH-1:0]) &&
                   (wr_ptr[C_DEPTH] != rd_ptr[C_DEPTH]);

    // A pop frees a slot this edge, so a push on full is still taken when paired with a pop.
    assign push_acc = push_i & (~full | pop_i);
    assign pop_acc  = pop_i & ~empty;

    always_comb begin
        level_nxt = level;
        if (push_acc && !pop_acc)      level_nxt = level + ONE;
        else if (!push_acc && pop_acc) level_nxt = level - ONE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hwm    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hwm    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (push_acc)               wr_ptr <= wr_ptr + ONE;
            if (pop_acc)                rd_ptr <= rd_ptr + ONE;
            if (level_nxt > hwm)        hwm    <= level_nxt;
            if (push_i & full & ~pop_i) ovf    <= 1'b1;
            if (pop_i & empty)          unf    <= 1'b1;
        end
    end

    fifo_dma_ram #(
        .C_WIDTH (C_WIDTH),
        .C_DEPTH (C_DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (push_acc & ~flush_i),
        .waddr (wr_ptr[C_DEPTH-1:0]),
        .wdata (data_i),
        .raddr (rd_ptr[C_DEPTH-1:0]),
        .rdata (data_o)
    );

    assign empty_o        = empty;
    assign full_o         = full;
    assign level_o        = level;
    assign almost_empty_o = (level <= AEMPTY_L);
    assign almost_full_o  = (level >= AFULL_L);
    assign hwm_o          = hwm;
    assign overflow_o     = ovf;
    assign underflow_o    = unf;

endmodule

// File: tb/tb_fifo_dma_flow.sv
// Randomised and directed bench for fifo_dma_flow against a queue-based reference model.
module tb_fifo_dma_flow;

    localparam int W   = 64;
    localparam int D   = 5;
    localparam int CAP = 32;
    localparam int AF  = 28;
    localparam int AE  = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          push_i = 1'b0;
    logic          pop_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          empty_o, full_o, almost_empty_o, almost_full_o;
    logic [D:0]    level_o, hwm_o;
    logic          overflow_o, underflow_o;

    fifo_dma_flow #(
        .C_WIDTH (W),
        .C_DEPTH (D),
        .C_AFULL (AF),
        .C_AEMPTY(AE)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .data_i        (data_i),
        .push_i        (push_i),
        .data_o        (data_o),
        .pop_i         (pop_i),
        .flush_i       (flush_i),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_empty_o(almost_empty_o),
        .almost_full_o (almost_full_o),
        .level_o       (level_o),
        .hwm_o         (hwm_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] q[$];
    int           m_hwm = 0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hwm = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input bit pu, input bit po, input bit fl, input logic [W-1:0] d);
        bit was_full, was_empty;
        if (fl) begin
            model_reset();
            return;
        end
        was_full  = (q.size() == CAP);
        was_empty = (q.size() == 0);
        if (po && was_empty)             m_unf = 1'b1;
        if (pu && was_full && !po)       m_ovf = 1'b1;
        if (po && !was_empty)            void'(q.pop_front());
        if (pu && (!was_full || po))     q.push_back(d);
        if (q.size() > m_hwm)            m_hwm = q.size();
    endtask

    task automatic cyc(input bit pu, input bit po, input bit fl, input logic [W-1:0] d);
        push_i  = pu;
        pop_i   = po;
        flush_i = fl;
        data_i  = d;
        @(posedge clk_i);
        model_edge(pu, po, fl, d);
        #1;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    // Every negedge: all status outputs against the model; head data only when non-empty.
    always @(negedge clk_i) begin
        int lvl;
        lvl = q.size();
        chk("empty",        W'(empty_o),        W'(lvl == 0));
        chk("full",         W'(full_o),         W'(lvl == CAP));
        chk("almost_empty", W'(almost_empty_o), W'(lvl <= AE));
        chk("almost_full",  W'(almost_full_o),  W'(lvl >= AF));
        chk("level",        W'(level_o),        W'(lvl));
        chk("hwm",          W'(hwm_o),          W'(m_hwm));
        chk("overflow",     W'(overflow_o),     W'(m_ovf));
        chk("underflow",    W'(underflow_o),    W'(m_unf));
        if (lvl != 0) chk("data", data_o, q[0]);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst_empty", W'(empty_o), W'(1));
        chk("rst_level", W'(level_o), W'(0));

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, W'(100 + i));
        chk("pre_rst_level", W'(level_o), W'(3));
        #2;
        rstn_i = 1'b0;
        model_reset();
        #1;
        chk("async_rst_level", W'(level_o), W'(0));
        chk("async_rst_empty", W'(empty_o), W'(1));
        chk("async_rst_hwm",   W'(hwm_o),   W'(0));
        @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // Fill to full, watching the almost-full threshold
        for (int i = 0; i < CAP; i++) begin
            cyc(1'b1, 1'b0, 1'b0, W'(i));
            if (i == 26) chk("af_at_27", W'(almost_full_o), W'(0));
            if (i == 27) chk("af_at_28", W'(almost_full_o), W'(1));
        end
        chk("fill_full",  W'(full_o),  W'(1));
        chk("fill_level", W'(level_o), W'(32));
        chk("fill_hwm",   W'(hwm_o),   W'(32));

        // Push+pop together on full
        chk("full_head", data_o, W'(0));
        cyc(1'b1, 1'b1, 1'b0, W'('hAA));
        chk("pp_full_level", W'(level_o),    W'(32));
        chk("pp_full_ovf",   W'(overflow_o), W'(0));
        chk("pp_full_head",  data_o,         W'(1));

        // Push on full without pop is dropped
        cyc(1'b1, 1'b0, 1'b0, W'('h99));
        chk("ovf_set",   W'(overflow_o), W'(1));
        chk("ovf_level", W'(level_o),    W'(32));

        for (int i = 1; i < CAP; i++) begin
            chk("drain_data", data_o, W'(i));
            cyc(1'b0, 1'b1, 1'b0, '0);
        end
        chk("drain_aa", data_o, W'('hAA));
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("drain_empty", W'(empty_o), W'(1));

        // Empty boundary
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("unf_set", W'(underflow_o), W'(1));
        cyc(1'b1, 1'b1, 1'b0, W'(5));
        chk("pp_empty_level", W'(level_o), W'(1));
        chk("pp_empty_data",  data_o,      W'(5));
        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("flush_unf",   W'(underflow_o), W'(0));
        chk("flush_ovf",   W'(overflow_o),  W'(0));
        chk("flush_level", W'(level_o),     W'(0));

        // Random traffic, long enough for several pointer wraps
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom});

        // Flush with a simultaneous push at level 10
        cyc(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, W'(200 + i));
        chk("pre_flush_level", W'(level_o), W'(10));
        cyc(1'b1, 1'b0, 1'b1, W'('h77));
        chk("flushp_level", W'(level_o), W'(0));
        chk("flushp_hwm",   W'(hwm_o),   W'(0));
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("flushp_empty", W'(empty_o), W'(1));

        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
